// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Write-back arbiter placed directly in front of the register file's single
// write port. Each cycle it picks the in-order pipeline write or the head of
// a small FIFO of long-latency (mul/div) results. It also keeps a per-register
// scoreboard of outstanding long-latency results so decode can stall on
// RAW/WAW hazards. A starvation counter briefly holds the pipeline when the
// FIFO has been blocked for too long.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   pipe_we/pipe_waddr/pipe_wdata pipeline write-back request
//   lu_valid/lu_ready             long-latency result handshake
//   lu_waddr/lu_wdata             long-latency result payload
//   issue_valid/issue_waddr       decode issued a long-latency op
//   busy_raddr1/2, busy1/2        scoreboard lookups for decode
//   stall_pipe                    hold the pipeline write-back this cycle
//   we/waddr/wdata                registered register-file write port
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_waddr,
  input  logic [ADDR_W-1:0] busy_raddr1,
  input  logic [ADDR_W-1:0] busy_raddr2,
  output logic              busy1,
  output logic              busy2,
  output logic              stall_pipe,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int SCW   = $clog2(STARVE_MAX + 1);
  localparam int NREG  = 1 << ADDR_W;

  // FIFO storage; head is read combinationally so a pop lands on the
  // registered write port at the same edge.
  logic [ADDR_W-1:0] fifo_addr_mem [QDEPTH];
  logic [DATA_W-1:0] fifo_data_mem [QDEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SCW-1:0]    starve_q, starve_d;
  logic              stall_q, stall_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              pipe_sel, fifo_empty, pop, push;
  logic [ADDR_W-1:0] head_waddr;
  logic [DATA_W-1:0] head_wdata;

  assign head_waddr = fifo_addr_mem[rd_ptr_q];
  assign head_wdata = fifo_data_mem[rd_ptr_q];

  // Held low during reset so no result is accepted and then thrown away.
  assign lu_ready = rst && (count_q < CNT_W'(QDEPTH));

  always_comb begin
    // While stalled the pipeline write is ignored; upstream re-presents it.
    pipe_sel   = !stall_q && pipe_we && (pipe_waddr != '0);
    fifo_empty = (count_q == '0);
    pop        = !pipe_sel && !fifo_empty;
    push       = lu_valid && lu_ready;

    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_sel) begin
      we_d    = 1'b1;
      waddr_d = pipe_waddr;
      wdata_d = pipe_wdata;
    end else if (pop && (head_waddr != '0)) begin
      // x0 entries are drained silently.
      we_d    = 1'b1;
      waddr_d = head_waddr;
      wdata_d = head_wdata;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Counts edges where a non-empty FIFO loses to the pipeline.
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (pipe_sel) begin
      starve_d = starve_q + SCW'(1);
    end else begin
      starve_d = starve_q;
    end
    // The stall cycle always pops, which clears the counter, so this is a
    // single-cycle pulse.
    stall_d = (starve_d == SCW'(STARVE_MAX));
  end

  // Scoreboard: one bit per architectural register, set wins over clear.
  // Bit 0 is never set, so x0 always reads as not busy.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pending
      if (gi == 0) begin : g_x0
        assign pending_d[gi] = 1'b0;
      end else begin : g_xn
        assign pending_d[gi] = (issue_valid && (issue_waddr == ADDR_W'(gi))) ||
                               (pending_q[gi] && !(pop && (head_waddr == ADDR_W'(gi))));
      end
    end
  endgenerate

  assign busy1 = pending_q[busy_raddr1] && (busy_raddr1 != '0);
  assign busy2 = pending_q[busy_raddr2] && (busy_raddr2 != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= lu_waddr;
      fifo_data_mem[wr_ptr_q] <= lu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      pending_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      pending_q <= pending_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign stall_pipe = stall_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter. Stimulus pushes every expected register-file
// write into a queue; an independent monitor pops and compares whenever the
// DUT asserts we. Control outputs are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_waddr;
  logic [DW-1:0] lu_wdata;
  logic          issue_valid;
  logic [AW-1:0] issue_waddr;
  logic [AW-1:0] busy_raddr1;
  logic [AW-1:0] busy_raddr2;
  logic          busy1;
  logic          busy2;
  logic          stall_pipe;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .QDEPTH(4), .STARVE_MAX(8)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready),
    .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .busy_raddr1(busy_raddr1), .busy_raddr2(busy_raddr2),
    .busy1(busy1), .busy2(busy2),
    .stall_pipe(stall_pipe),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one line per observed register-file write.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (rst && we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got x%0d=0x%0h, expected no write", waddr, wdata);
      end else begin
        w = exp_q.pop_front();
        $display("[MON] write x%0d = 0x%08h", waddr, wdata);
        check("wr_addr", 64'(waddr), 64'(w.a));
        check("wr_data", 64'(wdata), 64'(w.d));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst         = 1'b0;
    pipe_we     = 1'b0;
    pipe_waddr  = '0;
    pipe_wdata  = '0;
    lu_valid    = 1'b0;
    lu_waddr    = '0;
    lu_wdata    = '0;
    issue_valid = 1'b0;
    issue_waddr = '0;
    busy_raddr1 = 5'd7;
    busy_raddr2 = 5'd9;

    // ---- reset state ----
    step();
    step();
    check("rst_we", 64'(we), 64'(0));
    check("rst_waddr", 64'(waddr), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_lu_ready", 64'(lu_ready), 64'(0));
    check("rst_stall", 64'(stall_pipe), 64'(0));
    rst = 1'b1;
    #1;
    check("release_lu_ready", 64'(lu_ready), 64'(1));

    // ---- idle ----
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_we", 64'(we), 64'(0));
      check("idle_lu_ready", 64'(lu_ready), 64'(1));
      check("idle_busy1", 64'(busy1), 64'(0));
      check("idle_busy2", 64'(busy2), 64'(0));
    end

    // ---- pipeline write, then a write to x0 ----
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    check("pipe_we", 64'(we), 64'(1));
    check("pipe_waddr", 64'(waddr), 64'(5));
    check("pipe_wdata", 64'(wdata), 64'hDEADBEEF);
    pipe_waddr = 5'd0; pipe_wdata = 32'h11111111;
    step();
    check("x0_we", 64'(we), 64'(0));
    check("x0_waddr_hold", 64'(waddr), 64'(5));
    check("x0_wdata_hold", 64'(wdata), 64'hDEADBEEF);
    pipe_we = 1'b0;
    step();

    // ---- issue x7, long-latency result returns ----
    issue_valid = 1'b1; issue_waddr = 5'd7;
    step();
    issue_valid = 1'b0;
    check("busy7_after_issue", 64'(busy1), 64'(1));
    step();
    check("busy7_hold", 64'(busy1), 64'(1));
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h12345678;
    check("lu_ready_empty", 64'(lu_ready), 64'(1));
    expect_wr(5'd7, 32'h12345678);
    step();                                   // accept edge
    lu_valid = 1'b0;
    check("lu_busy_before_pop", 64'(busy1), 64'(1));
    check("lu_no_write_yet", 64'(we), 64'(0));
    step();                                   // pop edge
    check("lu_we", 64'(we), 64'(1));
    check("lu_waddr", 64'(waddr), 64'(7));
    check("lu_wdata", 64'(wdata), 64'h12345678);
    check("lu_busy_cleared", 64'(busy1), 64'(0));
    step();

    // ---- fill FIFO while the pipeline writes every cycle ----
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h100 + 32'(i);
      lu_valid = 1'b1; lu_waddr = 5'(10 + i); lu_wdata = 32'hA0 + 32'(i);
      expect_wr(5'd1, 32'h100 + 32'(i));
      step();
      check("fill_lu_ready", 64'(lu_ready), 64'(i < 3));
    end
    pipe_wdata = 32'h104; lu_waddr = 5'd14; lu_wdata = 32'hA4;
    expect_wr(5'd1, 32'h104);
    step();
    check("full_lu_ready", 64'(lu_ready), 64'(0));
    pipe_we = 1'b0;
    for (int i = 0; i < 5; i++) expect_wr(5'(10 + i), 32'hA0 + 32'(i));
    step();                                   // pop entry 0, 5th still waiting
    check("drain_head_addr", 64'(waddr), 64'(10));
    check("drain_lu_ready", 64'(lu_ready), 64'(1));
    step();                                   // 5th accepted
    lu_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("drain_done_we", 64'(we), 64'(0));

    // ---- starvation: one FIFO entry blocked by constant pipe writes ----
    for (int k = 0; k < 9; k++) begin
      pipe_we = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h5000 + 32'(k);
      if (k == 0) begin
        lu_valid = 1'b1; lu_waddr = 5'd20; lu_wdata = 32'hBEEF0020;
      end
      expect_wr(5'd2, 32'h5000 + 32'(k));
      step();
      lu_valid = 1'b0;
      check("starve_stall", 64'(stall_pipe), 64'(k == 8));
    end
    pipe_wdata = 32'h5009;                    // presented during stall, ignored
    expect_wr(5'd20, 32'hBEEF0020);
    step();
    check("stall_pop_we", 64'(we), 64'(1));
    check("stall_pop_addr", 64'(waddr), 64'(20));
    check("stall_one_cycle", 64'(stall_pipe), 64'(0));
    expect_wr(5'd2, 32'h5009);
    step();
    check("deferred_pipe_addr", 64'(waddr), 64'(2));
    check("deferred_pipe_data", 64'(wdata), 64'h5009);
    pipe_we = 1'b0;
    step();

    // ---- same-cycle issue and pop of x9: set wins ----
    issue_valid = 1'b1; issue_waddr = 5'd9;
    step();
    issue_valid = 1'b0;
    check("busy9_set", 64'(busy2), 64'(1));
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    expect_wr(5'd9, 32'h99);
    step();                                   // accept
    lu_valid = 1'b0;
    issue_valid = 1'b1; issue_waddr = 5'd9;
    step();                                   // pop + re-issue
    issue_valid = 1'b0;
    check("x9_we", 64'(we), 64'(1));
    check("x9_waddr", 64'(waddr), 64'(9));
    check("x9_busy_set_wins", 64'(busy2), 64'(1));
    step();
    check("x9_busy_persist", 64'(busy2), 64'(1));

    // ---- reset mid-burst ----
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h300;
    lu_valid = 1'b1; lu_waddr = 5'd11; lu_wdata = 32'hB1;
    expect_wr(5'd3, 32'h300);
    step();
    pipe_wdata = 32'h301; lu_waddr = 5'd12; lu_wdata = 32'hB2;
    expect_wr(5'd3, 32'h301);
    step();
    pipe_we = 1'b0; lu_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_we", 64'(we), 64'(0));
    check("arst_waddr", 64'(waddr), 64'(0));
    check("arst_wdata", 64'(wdata), 64'(0));
    check("arst_lu_ready", 64'(lu_ready), 64'(0));
    check("arst_stall", 64'(stall_pipe), 64'(0));
    check("arst_busy2", 64'(busy2), 64'(0));
    step();
    step();
    rst = 1'b1;
    #1;
    check("rerelease_lu_ready", 64'(lu_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_reset_no_write", 64'(we), 64'(0));
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
